// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of 2^N input vectors with settle wait, compare and error capture.
// States: IDLE reset/aborted | WAIT settle count | CHECK compare cycle | DONE results held.
module truth_table_sweeper #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         dut_f,
    input  logic         exp_f,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_err_valid,
    output logic [N-1:0] first_err_vec
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE  = N'(1);
    localparam logic [N:0]   ERR_ONE  = (N + 1)'(1);
    localparam logic [7:0]   CNT_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]   CNT_ONE  = 8'd1;

    state_t       state, state_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic [N-1:0] vec_nxt;
    logic [N:0]   err_nxt;
    logic         fev_nxt;
    logic [N-1:0] fevec_nxt;
    logic         busy_nxt;
    logic         done_nxt;
    logic         mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            vec             <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            vec             <= vec_nxt;
            err_count       <= err_nxt;
            first_err_valid <= fev_nxt;
            first_err_vec   <= fevec_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        err_nxt   = err_count;
        fev_nxt   = first_err_valid;
        fevec_nxt = first_err_vec;
        busy_nxt  = busy;
        done_nxt  = done;
        // Case inequality so an X/Z from either side is flagged in simulation.
        mismatch  = (dut_f !== exp_f);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    fev_nxt   = 1'b0;
                    fevec_nxt = '0;
                    done_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_nxt = err_count + ERR_ONE;
                        if (!first_err_valid) begin
                            fev_nxt   = 1'b1;
                            fevec_nxt = vec;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        state_nxt = S_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        vec_nxt   = vec + VEC_ONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven and random fault masks against a counting model,
// plus hand sequences for restart-while-busy, mid-sweep reset and abort corners.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N=3, SETTLE=1
    logic       start_a, abort_a, dut_a, exp_a;
    logic [2:0] vec_a, fvec_a;
    logic [3:0] err_a;
    logic       busy_a, done_a, pass_a, fvalid_a;
    logic [7:0] fault_a;

    // Instance B: N=2, SETTLE=3
    logic       start_b, abort_b, dut_b, exp_b;
    logic [1:0] vec_b, fvec_b;
    logic [2:0] err_b;
    logic       busy_b, done_b, pass_b, fvalid_b;

    truth_table_sweeper #(.N(3), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .dut_f(dut_a), .exp_f(exp_a), .vec(vec_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_valid(fvalid_a), .first_err_vec(fvec_a)
    );

    truth_table_sweeper #(.N(2), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .dut_f(dut_b), .exp_f(exp_b), .vec(vec_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_valid(fvalid_b), .first_err_vec(fvec_b)
    );

    // Golden function ~(a|(b&~c)); the block under test deviates where fault_a has a bit set.
    always_comb begin
        exp_a = ~(vec_a[2] | (vec_a[1] & ~vec_a[0]));
        dut_a = exp_a ^ fault_a[vec_a];
        exp_b = vec_b[1] ^ vec_b[0];
        dut_b = exp_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int faults_before(input logic [7:0] m, input int upto);
        int n = 0;
        for (int k = 0; k < upto && k < 8; k++) if (m[k]) n++;
        return n;
    endfunction

    function automatic int first_fault(input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return -1;
    endfunction

    // Called at a negedge. Vector k is held over edges E(2k)..E(2k+1) and compared at E(2k+2).
    task automatic sweep_a(input logic [7:0] mask, input logic with_abort);
        fault_a = mask;
        start_a = 1'b1;
        abort_a = with_abort;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("a_start_vec", vec_a, 0);
        chk("a_start_busy", busy_a, 1);
        chk("a_start_done", done_a, 0);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            chk("a_sweep_err", err_a, faults_before(mask, t / 2));
            if (t < 16) begin
                chk("a_sweep_vec", vec_a, t / 2);
                chk("a_sweep_busy", busy_a, 1);
                chk("a_sweep_done", done_a, 0);
            end else begin
                chk("a_end_vec", vec_a, 7);
                chk("a_end_busy", busy_a, 0);
                chk("a_end_done", done_a, 1);
            end
        end
    endtask

    task automatic final_a(input int e_err, input int e_fv, input int e_fvec, input int e_pass);
        chk("a_err_count", err_a, e_err);
        chk("a_first_valid", fvalid_a, e_fv);
        chk("a_first_vec", fvec_a, e_fvec);
        chk("a_pass", pass_a, e_pass);
    endtask

    typedef struct {
        logic [7:0] mask;
        int         err;
        int         fvalid;
        int         fvec;
        int         pass_exp;
    } rec_t;

    rec_t tbl[5];

    initial begin
        tbl[0] = '{8'h00, 0, 0, 0, 1};
        tbl[1] = '{8'h60, 2, 1, 5, 0};
        tbl[2] = '{8'hFF, 8, 1, 0, 0};
        tbl[3] = '{8'h80, 1, 1, 7, 0};
        tbl[4] = '{8'h01, 1, 1, 0, 0};

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; fault_a = 8'h00;
        start_b = 1'b0; abort_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vec", vec_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fvalid", fvalid_a, 0);
        chk("rst_fvec", fvec_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            sweep_a(tbl[i].mask, 1'b0);
            final_a(tbl[i].err, tbl[i].fvalid, tbl[i].fvec, tbl[i].pass_exp);
        end

        // abort in DONE is ignored
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("done_abort_done", done_a, 1);
        chk("done_abort_vec", vec_a, 7);
        chk("done_abort_err", err_a, 1);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] m;
            int         ff;
            m  = 8'($urandom);
            ff = first_fault(m);
            sweep_a(m, 1'b0);
            final_a(faults_before(m, 8), (ff >= 0) ? 1 : 0, (ff >= 0) ? ff : 0, (m == 8'h00) ? 1 : 0);
        end

        // mismatch at vec 1, reset sampled at E7
        fault_a = 8'h02;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("prerst_err", err_a, 1);
        chk("prerst_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vec", vec_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_err", err_a, 0);
        chk("midrst_fvalid", fvalid_a, 0);
        chk("midrst_fvec", fvec_a, 0);
        sweep_a(8'h00, 1'b0);
        final_a(0, 0, 0, 1);

        // mismatch at vec 2 counted at E6, abort sampled at E7
        fault_a = 8'h04;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("preabort_err", err_a, 1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_vec", vec_a, 3);
        chk("abort_err", err_a, 1);
        chk("abort_fvalid", fvalid_a, 1);
        chk("abort_fvec", fvec_a, 2);
        chk("abort_pass", pass_a, 0);
        @(negedge clk);
        chk("abort_idle_busy", busy_a, 0);
        chk("abort_idle_vec", vec_a, 3);
        sweep_a(8'h00, 1'b1);
        final_a(0, 0, 0, 1);

        // abort coinciding with a CHECK mismatch discards that mismatch
        fault_a = 8'h01;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abchk_err", err_a, 0);
        chk("abchk_fvalid", fvalid_a, 0);
        chk("abchk_vec", vec_a, 0);
        chk("abchk_busy", busy_a, 0);
        chk("abchk_done", done_a, 0);

        // instance B: 4 cycles per vector, start re-pulsed at E5 while busy
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_start_vec", vec_b, 0);
        chk("b_start_busy", busy_b, 1);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t < 16) begin
                chk("b_sweep_vec", vec_b, t / 4);
                chk("b_sweep_busy", busy_b, 1);
                chk("b_sweep_done", done_b, 0);
            end else begin
                chk("b_end_done", done_b, 1);
                chk("b_end_busy", busy_b, 0);
                chk("b_end_vec", vec_b, 3);
                chk("b_end_pass", pass_b, 1);
                chk("b_end_err", err_b, 0);
                chk("b_end_fvalid", fvalid_b, 0);
            end
            if (t == 4) start_b = 1'b1;
            if (t == 5) start_b = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, self-checking exhaustive stimulus engine for N-input single-output combinational blocks. It replaces hand-written per-vector bench sequences with a clocked sweep. On `start` it drives every input vector 0 … 2^N−1 in ascending order and holds each one for a programmable settle time. On the last cycle of each vector it compares the DUT output against a reference-model output, then reports mismatch count, first failing vector and a pass flag. It sits between the DUT (or a pure combinational golden model) and the bench or on-chip self-test controller.

## Interface
- `N`, 3: number of DUT inputs; legal range 1–16.
- `SETTLE`, 1: wait cycles per vector before its compare cycle; legal range 1–255.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `abort`  in  1  terminate a running sweep.
- `dut_f`  in  1  output of the block under test.
- `exp_f`  in  1  expected output from the reference model for the current `vec`.
- `vec`  out  N  stimulus vector; bit N−1 is the MSB (for N=3: {a,b,c}).
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep completed normally; held until the next `start` or `rst`.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  N+1  mismatches in the current or last sweep; cannot wrap (max 2^N).
- `first_err_valid`  out  1  at least one mismatch recorded.
- `first_err_vec`  out  N  `vec` value at the first mismatch.

## Operation
- FSM states:
  - IDLE: reset state.
  - WAIT: per-vector settle counter `cnt`, 0…SETTLE−1.
  - CHECK: compare cycle.
  - DONE.
- IDLE/DONE with `start`=1:
  - `vec`←0, `cnt`←0, `err_count`←0, `first_err_valid`←0, `first_err_vec`←0, `done`←0, `busy`←1.
  - Next state is WAIT.
- WAIT: `cnt` increments each cycle. When `cnt`==SETTLE−1, go to CHECK.
- CHECK: mismatch is `dut_f !== exp_f`, so X/Z on either input counts as a mismatch.
  - On mismatch: `err_count`+1. If `first_err_valid`==0, capture `first_err_vec`←`vec` and set `first_err_valid`←1.
  - If `vec`==2^N−1: go to DONE, `busy`←0, `done`←1. `vec` holds all-ones.
  - Otherwise: `vec`←`vec`+1, `cnt`←0, go to WAIT.
- DONE: all outputs hold until `start` or `rst`.
- `start` while busy (WAIT/CHECK) is ignored.
- `abort`=1 in WAIT or CHECK:
  - Go to IDLE, `busy`←0, `done`←0.
  - `err_count` and first-error fields keep their values at abort. If abort coincides with a CHECK mismatch, that mismatch is not counted.
  - `vec` holds its value.
- `abort` in IDLE/DONE has no effect. If `abort` and `start` are both high in IDLE/DONE, `start` wins.
- `rst` takes priority over everything, including mid-sweep. All outputs go to 0 and the state to IDLE on the next edge.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_vec`=0.
- Edge numbering: E0 is the edge that samples `start`. `vec`=0 and `busy`=1 are visible after E0.
- Each vector is stable for exactly SETTLE+1 cycles.
- Vector k is compared at edge E(k+1)·(SETTLE+1). `dut_f`/`exp_f` are sampled at that edge.
- `done`=1 and `busy`=0 are visible after edge E2^N·(SETTLE+1).
- Total sweep length is 2^N·(SETTLE+1) cycles. Example: N=3, SETTLE=1 gives 16 cycles.
- `pass` is combinational from `done` and `err_count`; no extra latency.
- A back-to-back `start` in DONE restarts immediately: `done` drops after the same edge.
- `err_count` and the first-error fields update on the edge following each CHECK cycle.

## Test plan
- N=3, SETTLE=1; `dut_f`=`exp_f`=~(a|(b&~c)) with {a,b,c}=`vec`; pulse `start` → `vec` steps 0..7 every 2 cycles; `done`=1 at E16; `pass`=1; `err_count`=0; `first_err_valid`=0.
- Same setup, but `dut_f` inverted only when `vec`==5 and again when `vec`==6 → `err_count`=2, `first_err_vec`=5, `pass`=0.
- `dut_f`=~`exp_f` for all vectors → `err_count`=8 (4'b1000, no wrap); `first_err_vec`=0.
- SETTLE=3, N=2 → each `vec` held 4 cycles; `done` at E16. `start` re-pulsed at E5 is ignored (`vec` is still 1 at E8).
- Mismatch at `vec`=1, then `rst` high at E6 mid-sweep → all outputs 0 after E7. A new `start` yields a clean full sweep.
- `abort` at E7 (N=3, SETTLE=1) with a mismatch injected at `vec`=2 → IDLE, `busy`=0, `done`=0; `err_count`=1 retained. `start` and `abort` together in IDLE starts a sweep.
